// File: rtl/imem_program_loader_pkg.sv
// imem_program_loader_pkg: shared FSM state encoding and default bus widths for the program loader
package imem_program_loader_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, HOLD = 2'd2, RUN = 2'd3} state_e;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/imem_program_loader_if.sv
// imem_program_loader_if: instruction stream in (in_data/in_valid/in_ready) and imem write port out (imem_wren/imem_addr/imem_data)
interface imem_program_loader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_wren;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  modport master (output in_data, in_valid, input in_ready, imem_wren, imem_addr, imem_data);
  modport slave  (input in_data, in_valid, output in_ready, imem_wren, imem_addr, imem_data);
endinterface

// File: rtl/imem_program_loader.sv
// imem_program_loader: streams words into imem at consecutive addresses, holding the processor in reset until loaded
//   clock/reset: sync active-high; start/num_words: begin a load; bus: stream in + imem write port;
//   proc_reset/busy/done: load status; checksum: sum of accepted words; error: sticky oversize request
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RST_HOLD = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W:0]      num_words,
  imem_program_loader_if.slave bus,
  output logic                 proc_reset,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          checksum,
  output logic                 error
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam int HW = $clog2(RST_HOLD + 1);
  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d, nw_q, nw_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [31:0]       sum_q, sum_d;
  logic              err_q, err_d, wren_q, wren_d, xfer;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  assign bus.in_ready  = state_q == LOAD;
  assign xfer          = bus.in_valid && bus.in_ready;
  assign bus.imem_wren = wren_q;
  assign bus.imem_addr = addr_q;
  assign bus.imem_data = data_q;
  assign proc_reset    = state_q != RUN;
  assign busy          = state_q == LOAD || state_q == HOLD;
  assign done          = state_q == RUN;
  assign checksum      = sum_q;
  assign error         = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nw_d    = nw_q;
    hold_d  = hold_q;
    sum_d   = sum_q;
    err_d   = err_q;
    wren_d  = xfer;
    addr_d  = xfer ? cnt_q[ADDR_W-1:0] : addr_q;
    data_d  = xfer ? bus.in_data : data_q;
    case (state_q)
      IDLE, RUN: if (start) begin
        if (num_words > DEPTH) err_d = 1'b1;
        else begin
          err_d   = 1'b0;
          sum_d   = '0;
          cnt_d   = '0;
          nw_d    = num_words;
          hold_d  = '0;
          state_d = num_words == '0 ? HOLD : LOAD;
        end
      end
      LOAD: if (xfer) begin
        sum_d   = sum_q + 32'(bus.in_data);
        cnt_d   = cnt_q + 1'b1;
        hold_d  = '0;
        state_d = cnt_q == nw_q - 1'b1 ? HOLD : LOAD;
      end
      // the HOLD entry cycle carries the final write; RST_HOLD more cycles follow before release
      HOLD: begin
        hold_d  = hold_q + 1'b1;
        state_d = hold_q == HW'(RST_HOLD) ? RUN : HOLD;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nw_q    <= '0;
      hold_q  <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nw_q    <= nw_d;
      hold_q  <= hold_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end
endmodule
